ps2_scancode_decoder: RTL

- Downstream consumer of the PS/2 frame receiver.
- Takes validated scan-code bytes (Set 2) one at a time and resolves E0/F0 prefixes into complete key events.
- Tracks the currently held key, suppresses typematic auto-repeat, and counts distinct key presses.
- Provides an ASCII translation for the display and 7-segment logic that follows it.

---
 rtl/ps2_pkg.sv | 32 +++
 rtl/ps2_ascii_rom.sv | 39 +++
 rtl/ps2_scancode_decoder.sv | 93 +++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 Set 2 scan-code path.
// Contents:
//   PS2_EXT / PS2_BRK - prefix bytes (extended, break)
//   is_ignored()      - device status/ack/error bytes that never form a key event
//   pfx_t             - prefix-flag state, bit 1 = ext_f, bit 0 = brk_f
package ps2_pkg;

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;

   localparam logic [7:0] PS2_ERR0   = 8'h00;
   localparam logic [7:0] PS2_BAT_OK = 8'hAA;
   localparam logic [7:0] PS2_ECHO   = 8'hEE;
   localparam logic [7:0] PS2_ACK    = 8'hFA;
   localparam logic [7:0] PS2_BAT_ER = 8'hFC;
   localparam logic [7:0] PS2_RESEND = 8'hFE;
   localparam logic [7:0] PS2_ERR1   = 8'hFF;

   typedef enum logic [1:0] {
      PFX_IDLE    = 2'b00,
      PFX_BRK     = 2'b01,
      PFX_EXT     = 2'b10,
      PFX_EXT_BRK = 2'b11
   } pfx_t;

   function automatic logic is_ignored(input logic [7:0] b);
      return (b == PS2_ERR0)   || (b == PS2_BAT_OK) || (b == PS2_ECHO) ||
             (b == PS2_ACK)    || (b == PS2_BAT_ER) || (b == PS2_RESEND) ||
             (b == PS2_ERR1);
   endfunction

endpackage

// File: rtl/ps2_ascii_rom.sv
// Combinational Set 2 scan code to ASCII lookup.
// Ports:
//   code  in  8  scan code (without prefixes)
//   ext   in  1  code carried an E0 prefix; extended keys have no ASCII
//   ascii out 8  lower-case letter, digit, space, CR or BS; 0x00 otherwise
module ps2_ascii_rom
   import ps2_pkg::*;
(
   input  logic [7:0] code,
   input  logic       ext,
   output logic [7:0] ascii
);

   always_comb begin
      ascii = 8'h00;
      if (!ext) begin
         case (code)
            8'h1C: ascii = 8'h61; 8'h32: ascii = 8'h62; 8'h21: ascii = 8'h63;
            8'h23: ascii = 8'h64; 8'h24: ascii = 8'h65; 8'h2B: ascii = 8'h66;
            8'h34: ascii = 8'h67; 8'h33: ascii = 8'h68; 8'h43: ascii = 8'h69;
            8'h3B: ascii = 8'h6A; 8'h42: ascii = 8'h6B; 8'h4B: ascii = 8'h6C;
            8'h3A: ascii = 8'h6D; 8'h31: ascii = 8'h6E; 8'h44: ascii = 8'h6F;
            8'h4D: ascii = 8'h70; 8'h15: ascii = 8'h71; 8'h2D: ascii = 8'h72;
            8'h1B: ascii = 8'h73; 8'h2C: ascii = 8'h74; 8'h3C: ascii = 8'h75;
            8'h2A: ascii = 8'h76; 8'h1D: ascii = 8'h77; 8'h22: ascii = 8'h78;
            8'h35: ascii = 8'h79; 8'h1A: ascii = 8'h7A;
            8'h45: ascii = 8'h30; 8'h16: ascii = 8'h31; 8'h1E: ascii = 8'h32;
            8'h26: ascii = 8'h33; 8'h25: ascii = 8'h34; 8'h2E: ascii = 8'h35;
            8'h36: ascii = 8'h36; 8'h3D: ascii = 8'h37; 8'h3E: ascii = 8'h38;
            8'h46: ascii = 8'h39;
            8'h29: ascii = 8'h20;
            8'h5A: ascii = 8'h0D;
            8'h66: ascii = 8'h08;
            default: ascii = 8'h00;
         endcase
      end
   end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Resolves E0/F0 prefixed Set 2 scan-code bytes into key events, tracks the
// single held key (suppressing typematic repeats in the press count) and
// provides an ASCII translation of the last event.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   byte_data/valid     validated scan-code byte and its one-cycle strobe
//   event_valid         one-cycle strobe, cycle after the completing byte
//   event_make/ext      make(1)/break(0) and E0 flag of the last event
//   key_code, ascii     last event code and its ASCII (0x00 if none)
//   key_held            a key is currently held
//   press_count         distinct presses since reset, wraps modulo 2^CNT_W
module ps2_scancode_decoder
   import ps2_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       byte_data,
   input  logic             byte_valid,
   output logic             event_valid,
   output logic             event_make,
   output logic             event_ext,
   output logic [7:0]       key_code,
   output logic [7:0]       ascii,
   output logic             key_held,
   output logic [CNT_W-1:0] press_count
);

   pfx_t       pfx_p1;
   logic [7:0] held_code_p1;
   logic       held_ext_p1;

   logic ext_f;
   logic brk_f;
   logic held_match;

   assign ext_f      = pfx_p1[1];
   assign brk_f      = pfx_p1[0];
   // A key is "the same" only if both its code and its E0 flag agree.
   assign held_match = key_held && (held_ext_p1 == ext_f) && (held_code_p1 == byte_data);

   // Byte in -> registered prefix state, event outputs and held-key state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pfx_p1       <= PFX_IDLE;
         held_code_p1 <= 8'h00;
         held_ext_p1  <= 1'b0;
         key_held     <= 1'b0;
         press_count  <= '0;
         event_valid  <= 1'b0;
         event_make   <= 1'b0;
         event_ext    <= 1'b0;
         key_code     <= 8'h00;
      end else begin
         event_valid <= 1'b0;
         if (byte_valid) begin
            if (byte_data == PS2_EXT) begin
               pfx_p1 <= pfx_t'({1'b1, brk_f});
            end else if (byte_data == PS2_BRK) begin
               pfx_p1 <= pfx_t'({ext_f, 1'b1});
            end else if (is_ignored(byte_data)) begin
               pfx_p1 <= PFX_IDLE;
            end else begin
               pfx_p1      <= PFX_IDLE;
               event_valid <= 1'b1;
               event_make  <= ~brk_f;
               event_ext   <= ext_f;
               key_code    <= byte_data;
               if (!brk_f) begin
                  // A make of the already-held key is typematic repeat.
                  if (!held_match) begin
                     held_code_p1 <= byte_data;
                     held_ext_p1  <= ext_f;
                     key_held     <= 1'b1;
                     press_count  <= press_count + CNT_W'(1);
                  end
               end else if (held_match) begin
                  key_held <= 1'b0;
               end
            end
         end
      end
   end

   // Registered event code -> combinational ASCII
   ps2_ascii_rom u_ascii_rom (
      .code  (key_code),
      .ext   (event_ext),
      .ascii (ascii)
   );

endmodule
